// File: rtl/max7219_frame_tx.sv
// rtl/max7219_frame_tx.sv - FIFO-buffered 16-bit MAX7219 frame serializer
module max7219_frame_tx #(
  parameter int DIVIDER    = 22,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mosi,
  output logic        sclk,
  output logic        sel,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(DIVIDER + 1);
  localparam logic [DW-1:0] DIV_RELOAD = DW'(DIVIDER);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, END, LATCH} state_t;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_next, rd_next;
  logic          push, pop, empty, full_next, empty_next, idle_next, expire;
  logic [15:0]   head;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_idx;
  logic [15:0]   shreg;

  assign empty  = (wr_ptr == rd_ptr);
  assign push   = in_valid && in_ready;
  assign pop    = (state == IDLE) && !empty;
  assign expire = (div_cnt == '0);
  assign head   = mem[rd_ptr[AW-1:0]];

  // Post-edge FIFO/FSM status, so in_ready and busy can be registered without lag
  always_comb begin
    wr_next    = wr_ptr + {{AW{1'b0}}, push};
    rd_next    = rd_ptr + {{AW{1'b0}}, pop};
    full_next  = (wr_next[AW-1:0] == rd_next[AW-1:0]) && (wr_next[AW] != rd_next[AW]);
    empty_next = (wr_next == rd_next);
    idle_next  = ((state == IDLE) && empty) || ((state == LATCH) && expire);
  end

  // Frame storage; no reset needed because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // FIFO pointers and registered in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b1;
    end else begin
      wr_ptr   <= wr_next;
      rd_ptr   <= rd_next;
      in_ready <= !full_next;
    end
  end

  // Serializer FSM: each non-IDLE state lasts one half-period of DIVIDER+1 clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= DIV_RELOAD;
      bit_idx <= 4'd15;
      shreg   <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      sel     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      busy <= !(idle_next && empty_next);
      if (state == IDLE) begin
        div_cnt <= DIV_RELOAD;
        if (pop) begin
          shreg   <= head;
          mosi    <= head[15];
          sel     <= 1'b0;
          sclk    <= 1'b0;
          bit_idx <= 4'd15;
          state   <= SETUP;
        end
      end else if (!expire) begin
        div_cnt <= div_cnt - DW'(1);
      end else begin
        div_cnt <= DIV_RELOAD;
        case (state)
          SETUP, LOW: begin
            state <= HIGH;
            sclk  <= 1'b1;
          end
          HIGH: begin
            sclk <= 1'b0;
            if (bit_idx != 4'd0) begin
              bit_idx <= bit_idx - 4'd1;
              mosi    <= shreg[bit_idx - 4'd1];
              state   <= LOW;
            end else begin
              mosi  <= 1'b0;
              state <= END;
            end
          end
          END: begin
            sel   <= 1'b1;
            state <= LATCH;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_max7219_frame_tx.sv
// tb/tb_max7219_frame_tx.sv - directed self-checking bench for max7219_frame_tx
module tb_max7219_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready, mosi, sclk, sel, busy;

  logic [15:0] b_data;
  logic        b_valid;
  logic        b_in_ready, b_mosi, b_sclk, b_sel, b_busy;

  max7219_frame_tx #(.DIVIDER(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mosi(mosi), .sclk(sclk), .sel(sel), .busy(busy)
  );

  max7219_frame_tx #(.DIVIDER(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_in_ready), .mosi(b_mosi), .sclk(b_sclk), .sel(b_sel), .busy(b_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Line monitor for the DIVIDER=2 instance, sampled on the falling clk edge
  logic        prev_sclk, prev_sel;
  logic [15:0] cap;
  int          nbits, low_cnt, high_cnt;
  int          stray = 0;
  int          rise_total = 0;
  logic [15:0] got_data[$];
  int          got_bits[$], got_low[$], got_gap[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sclk <= 1'b0;
      prev_sel  <= 1'b1;
      cap       <= '0;
      nbits     <= 0;
      low_cnt   <= 0;
      high_cnt  <= 0;
    end else begin
      prev_sclk <= sclk;
      prev_sel  <= sel;
      if (sclk && !prev_sclk) begin
        cap        <= {cap[14:0], mosi};
        nbits      <= nbits + 1;
        rise_total <= rise_total + 1;
        if (sel) stray <= stray + 1;
      end
      if (!sel) begin
        if (prev_sel) begin
          got_gap.push_back(high_cnt);
          low_cnt <= 1;
        end else begin
          low_cnt <= low_cnt + 1;
        end
      end else begin
        if (!prev_sel) begin
          got_data.push_back(cap);
          got_bits.push_back(nbits);
          got_low.push_back(low_cnt);
          nbits    <= 0;
          high_cnt <= 1;
        end else begin
          high_cnt <= high_cnt + 1;
        end
      end
    end
  end

  task automatic clear_caps();
    got_data.delete();
    got_bits.delete();
    got_low.delete();
    got_gap.delete();
  endtask

  // Present one frame from a falling edge; returns on the falling edge after acceptance
  task automatic push(input logic [15:0] d);
    int t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: actual=in_ready_low required=accept of %h", d);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < limit);
    check("wait_idle_busy", busy, 0);
  endtask

  task automatic check_frame(input string name, input logic [15:0] exp);
    if (got_data.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: actual=no_frame required=%h", name, exp);
    end else begin
      check(name, got_data.pop_front(), exp);
      check({name, "_bits"}, got_bits.pop_front(), 16);
      check({name, "_sel_low"}, got_low.pop_front(), 99);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic [15:0] exp_bits;
  } vec_t;

  vec_t        vecs[3];
  logic [15:0] fifo_frames[6];
  logic [15:0] wrap_frames[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int          snap, t, bl, bh, brise;
    logic        bprev;
    logic [15:0] bcap;

    vecs[0] = '{16'h0C01, 16'b0000110000000001};
    vecs[1] = '{16'hA55A, 16'b1010010101011010};
    vecs[2] = '{16'h0F80, 16'b0000111110000000};
    fifo_frames = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
    for (int i = 0; i < 10; i++) wrap_frames[i] = 16'h3000 + 16'(i * 16'h0111);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; b_valid = 1'b0; b_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sel", sel, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames from the table
    for (int i = 0; i < 3; i++) begin
      clear_caps();
      push(vecs[i].data);
      in_valid = 1'b0;
      wait_idle(400);
      check_frame($sformatf("single%0d", i), vecs[i].exp_bits);
    end

    // Back-to-back frames written on consecutive cycles
    clear_caps();
    push(16'h0900);
    push(16'h0A04);
    in_valid = 1'b0;
    wait_idle(600);
    check_frame("b2b_first", 16'h0900);
    check_frame("b2b_second", 16'h0A04);
    check("b2b_gap_count", got_gap.size(), 2);
    if (got_gap.size() >= 2) check("b2b_sel_high_gap", got_gap[1], 4);

    // Six continuous writes against a four-deep FIFO
    clear_caps();
    for (int i = 0; i < 5; i++) push(fifo_frames[i]);
    check("full_in_ready_low", in_ready, 0);
    push(fifo_frames[5]);
    in_valid = 1'b0;
    wait_idle(1000);
    for (int i = 0; i < 6; i++) check_frame($sformatf("full%0d", i), fifo_frames[i]);

    // Pointer wrap with 1-3 frames queued
    clear_caps();
    for (int i = 0; i < 10; i++) begin
      push(wrap_frames[i]);
      in_valid = 1'b0;
      repeat (70) @(negedge clk);
    end
    wait_idle(2000);
    for (int i = 0; i < 10; i++) check_frame($sformatf("wrap%0d", i), wrap_frames[i]);
    check("wrap_extra_frames", got_data.size(), 0);

    // Reset after the 7th sclk rise of 16'hFFFF with two frames queued
    clear_caps();
    push(16'hFFFF);
    push(16'h1111);
    push(16'h2222);
    in_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (nbits != 7 && t < 500);
    check("mid_reach_7_rises", nbits, 7);
    check("mid_mosi_before_reset", mosi, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", sel, 1);
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_mosi", mosi, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap = rise_total;
    repeat (300) @(negedge clk);
    check("post_rst_no_sclk", rise_total, snap);
    check("post_rst_no_frame", got_data.size(), 0);
    check("post_rst_busy", busy, 0);
    push(16'h1234);
    in_valid = 1'b0;
    wait_idle(400);
    check_frame("post_rst_frame", 16'h1234);
    check("no_sclk_outside_sel", stray, 0);

    // DIVIDER=1 instance: half-period 2 clk, 68 clk from SETUP to IDLE
    @(negedge clk);
    b_data  = 16'h0F01;
    b_valid = 1'b1;
    check("b_in_ready", b_in_ready, 1);
    @(negedge clk);
    b_valid = 1'b0;
    check("b_sel_after_write", b_sel, 1);
    @(negedge clk);
    check("b_sel_after_pop", b_sel, 0);
    bl = 1; bh = 0; brise = 0; bcap = '0; bprev = b_sclk; t = 0;
    while (b_sel == 1'b0 && t < 500) begin
      @(negedge clk);
      t++;
      if (b_sclk && !bprev) begin
        bcap = {bcap[14:0], b_mosi};
        brise++;
      end
      bprev = b_sclk;
      if (!b_sel) bl++;
    end
    while (b_busy && t < 500) begin
      bh++;
      @(negedge clk);
      t++;
    end
    check("b_bits", bcap, 16'b0000111100000001);
    check("b_rises", brise, 16);
    check("b_sel_low", bl, 66);
    check("b_frame_len", bl + bh, 68);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
